// File: rtl/ram32_pkg.sv
// ram32_pkg: shared definitions for the ram32 arbiter slice.
//   - default geometry constants (DEPTH, AW, STARVE)
//   - grant encoding (GNT_NONE, GNT_I, GNT_D)
//   - requester response FSM state type and next-state helper
package ram32_pkg;

    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int STARVE = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } gnt_e;

    typedef logic [0:0] req_state_t;

    localparam req_state_t IDLE = 1'b0;
    localparam req_state_t RESP = 1'b1;

    // A port sits in RESP for exactly the cycle after each grant; a fresh
    // grant while in RESP keeps it there, so back-to-back accepts stream.
    function automatic req_state_t next_req_state(input req_state_t cur,
                                                  input logic       granted);
        req_state_t nxt;
        case (cur)
            IDLE:    nxt = granted ? RESP : IDLE;
            RESP:    nxt = granted ? RESP : IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ram32_adr_chk.sv
// ram32_adr_chk: combinational decode of a byte address into a RAM word index.
// Ports:
//   adr        in  32  byte address of the granted requester
//   word       out AW  word index (adr[31:2] truncated to AW bits)
//   misaligned out 1   low two address bits are non-zero
//   oob        out 1   full word index is at or beyond DEPTH
module ram32_adr_chk #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic [31:0]   adr,
    output logic [AW-1:0] word,
    output logic          misaligned,
    output logic          oob
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [29:0] word_full_s;

    // Split the byte address; the range check uses all 30 word bits so that
    // aliases above DEPTH are caught before truncation.
    always_comb begin
        word_full_s = adr[31:2];
        word        = word_full_s[AW-1:0];
        misaligned  = (adr[1:0] != 2'b00);
        oob         = (word_full_s >= DEPTH_W);
    end

endmodule

// File: rtl/ram32_arb.sv
// ram32_arb: two-requester (fetch I, data D) arbiter/sequencer in front of a
// single-port word RAM with combinational read data.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_req/i_adr                    fetch request and byte address
//   i_ready                        fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata/i_err         fetch response, one cycle after accept
//   d_req/d_we/d_adr/d_wdata       data request
//   d_ready                        data accepted this cycle (combinational)
//   d_rvalid/d_rdata/d_err         data response, one cycle after accept
//   ram_en/ram_we/ram_adr/ram_din  RAM drive
//   ram_dout                       RAM read data, combinational from ram_adr
module ram32_arb
    import ram32_pkg::*;
#(
    parameter int DEPTH  = ram32_pkg::DEPTH,
    parameter int AW     = ram32_pkg::AW,
    parameter int STARVE = ram32_pkg::STARVE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [31:0]   i_adr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_adr,
    input  logic [31:0]   d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    localparam logic [3:0] STARVE_W = 4'(STARVE);

    gnt_e         gnt_s;
    logic         i_gnt_s;
    logic         d_gnt_s;
    logic [31:0]  gnt_adr_s;
    logic [AW-1:0] word_s;
    logic         misaligned_s;
    logic         oob_s;
    logic         bad_s;

    logic [3:0]   starve_cnt_r;
    req_state_t   i_state_r;
    req_state_t   d_state_r;
    logic [31:0]  i_rdata_r;
    logic         i_err_r;
    logic [31:0]  d_rdata_r;
    logic         d_err_r;

    // Priority arbitration: D wins ties until it has starved I STARVE times.
    always_comb begin
        gnt_s = GNT_NONE;
        if (rst) begin
            gnt_s = GNT_NONE;
        end else if (i_req && d_req) begin
            gnt_s = (starve_cnt_r < STARVE_W) ? GNT_D : GNT_I;
        end else if (d_req) begin
            gnt_s = GNT_D;
        end else if (i_req) begin
            gnt_s = GNT_I;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Route the winner's address into the single shared decoder.
    always_comb begin
        case (gnt_s)
            GNT_I:   gnt_adr_s = i_adr;
            GNT_D:   gnt_adr_s = d_adr;
            default: gnt_adr_s = 32'h0000_0000;
        endcase
    end

    ram32_adr_chk #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_adr_chk (
        .adr        (gnt_adr_s),
        .word       (word_s),
        .misaligned (misaligned_s),
        .oob        (oob_s)
    );

    assign bad_s   = misaligned_s | oob_s;
    assign i_gnt_s = (gnt_s == GNT_I);
    assign d_gnt_s = (gnt_s == GNT_D);
    assign i_ready = i_gnt_s;
    assign d_ready = d_gnt_s;

    // RAM drive: only a good grant touches the RAM, so a bad write is dropped.
    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_adr = '0;
        ram_din = 32'h0000_0000;
        if ((gnt_s != GNT_NONE) && !bad_s) begin
            ram_en  = 1'b1;
            ram_we  = d_gnt_s ? d_we : 1'b0;
            ram_adr = word_s;
            ram_din = d_wdata;
        end else begin
            ram_en  = 1'b0;
            ram_we  = 1'b0;
        end
    end

    // Count consecutive D wins that left I waiting; any other cycle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (d_gnt_s && i_req) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= 4'd0;
        end
    end

    // Response FSMs and data/error registers, captured at the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_r <= IDLE;
            d_state_r <= IDLE;
            i_rdata_r <= 32'h0000_0000;
            i_err_r   <= 1'b0;
            d_rdata_r <= 32'h0000_0000;
            d_err_r   <= 1'b0;
        end else begin
            i_state_r <= next_req_state(i_state_r, i_gnt_s);
            d_state_r <= next_req_state(d_state_r, d_gnt_s);
            i_rdata_r <= (i_gnt_s && !bad_s) ? ram_dout : 32'h0000_0000;
            i_err_r   <= i_gnt_s & bad_s;
            d_rdata_r <= (d_gnt_s && !bad_s && !d_we) ? ram_dout : 32'h0000_0000;
            d_err_r   <= d_gnt_s & bad_s;
        end
    end

    assign i_rvalid = (i_state_r == RESP);
    assign i_rdata  = i_rdata_r;
    assign i_err    = i_err_r;
    assign d_rvalid = (d_state_r == RESP);
    assign d_rdata  = d_rdata_r;
    assign d_err    = d_err_r;

endmodule

// File: tb/tb_ram32_arb.sv
// tb_ram32_arb: directed plus randomized bench for ram32_arb. A behavioural
// RAM sits on the RAM pins; a separate reference memory and a plain
// arbitration model predict every grant and response.
module tb_ram32_arb;

    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [31:0]   i_adr;
    logic          i_ready;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_adr;
    logic [31:0]   d_wdata;
    logic          d_ready;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    logic [31:0] mem     [0:DEPTH-1] = '{default: 32'h0};
    logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_starve = 0;
    logic acc_i = 1'b0;
    logic acc_d = 1'b0;
    logic obs_d_ready = 1'b0;

    always #5 clk = ~clk;

    ram32_arb #(.DEPTH(DEPTH), .AW(AW), .STARVE(STARVE)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_adr    (i_adr),
        .i_ready  (i_ready),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_adr    (d_adr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_adr  (ram_adr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural single-port RAM: combinational read, write at the edge.
    assign ram_dout = mem[ram_adr];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_adr] <= ram_din;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] rand_adr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) return 32'(4 * DEPTH) + (32'($urandom_range(0, 255)) << 2);
        else return 32'($urandom_range(0, 31)) << 2;
    endfunction

    // One clock cycle: inputs are already set (just after a falling edge).
    task automatic step();
        logic        e_gi, e_gd, e_bad;
        logic [31:0] a;
        int          w;
        logic [31:0] e_ird, e_drd;
        e_gi = 1'b0;
        e_gd = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (m_starve < STARVE) e_gd = 1'b1;
                else e_gi = 1'b1;
            end else begin
                e_gd = d_req;
                e_gi = i_req;
            end
        end
        a     = e_gd ? d_adr : i_adr;
        e_bad = is_bad(a);
        w     = int'(a[11:2]);
        #1;
        obs_d_ready = d_ready;
        chk1("i_ready", i_ready, e_gi);
        chk1("d_ready", d_ready, e_gd);
        chk1("ram_en", ram_en, (e_gi | e_gd) & ~e_bad);
        chk1("ram_we", ram_we, e_gd & d_we & ~e_bad);
        if ((e_gi | e_gd) && !e_bad) chk32("ram_adr", {22'b0, ram_adr}, a >> 2);
        e_ird = (e_gi && !e_bad) ? ref_mem[w] : 32'h0;
        e_drd = (e_gd && !e_bad && !d_we) ? ref_mem[w] : 32'h0;
        @(posedge clk);
        if (e_gd && !e_bad && d_we) ref_mem[w] = d_wdata;
        if (rst) m_starve = 0;
        else if (e_gd && i_req) m_starve = m_starve + 1;
        else m_starve = 0;
        acc_i = e_gi;
        acc_d = e_gd;
        @(negedge clk);
        chk1("i_rvalid", i_rvalid, e_gi);
        chk32("i_rdata", i_rdata, e_ird);
        chk1("i_err", i_err, e_gi & e_bad);
        chk1("d_rvalid", d_rvalid, e_gd);
        chk32("d_rdata", d_rdata, e_drd);
        chk1("d_err", d_err, e_gd & e_bad);
    endtask

    initial begin
        logic [5:0] pat;
        rst = 1'b1; i_req = 1'b1; i_adr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h10; d_wdata = 32'h0;
        @(negedge clk);

        // Reset held three cycles with both requesting.
        for (int k = 0; k < 3; k++) step();

        // Idle cycle out of reset.
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step();

        // Write then fetch the same word.
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h10; d_wdata = 32'hDEADBEEF;
        step();
        d_req = 1'b0; d_we = 1'b0;
        i_req = 1'b1; i_adr = 32'h10;
        step();
        chk32("single_read_data", i_rdata, 32'hDEADBEEF);
        i_req = 1'b0;
        step();

        // Starvation: D held with reads, I held; expect D D D D I D.
        pat = 6'b101111;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h10;
        i_req = 1'b1; i_adr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            step();
            chk1("starve_dgrant", obs_d_ready, pat[k]);
            if (acc_i) i_req = 1'b0;
        end
        d_req = 1'b0;
        step();

        // Error accesses: misaligned write and out-of-range read.
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h2; d_wdata = 32'h12345678;
        step();
        chk1("err_write_err", d_err, 1'b1);
        d_we = 1'b0; d_adr = 32'(4 * DEPTH);
        step();
        chk1("err_read_err", d_err, 1'b1);
        chk32("err_read_data", d_rdata, 32'h0);
        d_req = 1'b0;
        step();
        chk32("err_mem_word0", mem[0], 32'h0);

        // Reset mid-operation with starve count built up and a write pending.
        i_req = 1'b1; i_adr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h10;
        step();
        step();
        rst = 1'b1; d_we = 1'b1; d_adr = 32'h20; d_wdata = 32'hBAD0BAD0;
        step();
        chk1("rst_mid_rvalid", d_rvalid, 1'b0);
        chk32("rst_mid_starve", 32'(dut.starve_cnt_r), 32'h0);
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        chk32("rst_mid_no_write", mem[8], 32'h0);

        // Randomized traffic with hold-until-accepted requesters.
        acc_i = 1'b0; acc_d = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!i_req || acc_i) begin
                i_req = ($urandom_range(0, 3) != 0);
                i_adr = rand_adr();
            end
            if (!d_req || acc_d) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_adr   = rand_adr();
                d_wdata = $urandom;
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step();
        for (int k = 0; k < 32; k++) chk32("final_mem", mem[k], ref_mem[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
